// File: rtl/line_steer_fsm.sv
// Line follower steering FSM: classifies an N-sensor vector and drives
// left/right servo bytes in bang-bang or PID mode, with dwell, coast and search.
module line_steer_fsm #(
    parameter int NSENS         = 5,
    parameter int SPD_W         = 8,
    parameter int FWD_L         = 155,
    parameter int FWD_R         = 137,
    parameter int TURN_CYCLES   = 500,
    parameter int LOST_CYCLES   = 1000,
    parameter int SEARCH_CYCLES = 200000,
    parameter int CNT_W         = 21
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [NSENS-1:0]        sensors,
    input  logic signed [12:0]      pid_output,
    output logic [SPD_W-1:0]        servo_l,
    output logic [SPD_W-1:0]        servo_r,
    output logic [2:0]              state_o,
    output logic                    lost
);

    localparam int HALF   = NSENS / 2;
    localparam int PC_W   = $clog2(NSENS + 1);
    localparam int LOST_W = $clog2(LOST_CYCLES + 1);
    localparam int SMAX   = (1 << SPD_W) - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FWD    = 3'd1;
    localparam logic [2:0] S_TURN_L = 3'd2;
    localparam logic [2:0] S_TURN_R = 3'd3;
    localparam logic [2:0] S_SEARCH = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    localparam logic [1:0] C_NONE   = 2'd0;
    localparam logic [1:0] C_LEFT   = 2'd1;
    localparam logic [1:0] C_RIGHT  = 2'd2;
    localparam logic [1:0] C_CENTER = 2'd3;

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [LOST_W-1:0]  r_lost_cnt;
    logic               r_last_dir;
    logic [SPD_W-1:0]   r_servo_l;
    logic [SPD_W-1:0]   r_servo_r;

    logic [PC_W-1:0]    w_l_cnt;
    logic [PC_W-1:0]    w_r_cnt;
    logic               w_any;
    logic [1:0]         w_cls;
    logic [1:0]         w_cls_m;
    logic [2:0]         w_state_nxt;
    logic               w_cnt_inc;
    logic               w_lost_inc;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [LOST_W-1:0]  w_lost_nxt;
    logic               w_last_dir_nxt;
    logic signed [14:0] w_pid_ext;
    logic signed [14:0] w_sum_l;
    logic signed [14:0] w_sum_r;
    logic [SPD_W-1:0]   w_servo_l_nxt;
    logic [SPD_W-1:0]   w_servo_r_nxt;

    function automatic logic [2:0] f_steer(
        input logic [1:0] c,
        input logic [2:0] on_none
    );
        logic [2:0] s;
        case (c)
            C_NONE:  s = on_none;
            C_LEFT:  s = S_TURN_L;
            C_RIGHT: s = S_TURN_R;
            default: s = S_FWD;
        endcase
        return s;
    endfunction

    function automatic logic [SPD_W-1:0] f_sat(
        input logic signed [14:0] v
    );
        logic [SPD_W-1:0] o;
        if (v[14])
            o = '0;
        else if (v[13:0] > 14'(SMAX))
            o = '1;
        else
            o = v[SPD_W-1:0];
        return o;
    endfunction

    // The middle bit of an odd-width array only contributes to w_any.
    always_comb begin
        w_l_cnt = '0;
        w_r_cnt = '0;
        for (int i = 0; i < HALF; i++) begin
            w_r_cnt = w_r_cnt + PC_W'(sensors[i]);
            w_l_cnt = w_l_cnt + PC_W'(sensors[NSENS-1-i]);
        end
    end

    assign w_any = |sensors;

    always_comb begin
        w_cls = C_CENTER;
        unique case (1'b1)
            !w_any:              w_cls = C_NONE;
            (w_l_cnt > w_r_cnt): w_cls = C_LEFT;
            (w_r_cnt > w_l_cnt): w_cls = C_RIGHT;
            default:             w_cls = C_CENTER;
        endcase
    end

    assign w_cls_m = (mode && (w_cls == C_LEFT || w_cls == C_RIGHT))
                   ? C_CENTER : w_cls;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_inc   = 1'b0;
        w_lost_inc  = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = f_steer(w_cls_m, S_STOP);
                S_FWD: begin
                    unique case (w_cls_m)
                        C_LEFT:  w_state_nxt = S_TURN_L;
                        C_RIGHT: w_state_nxt = S_TURN_R;
                        C_NONE: begin
                            if (r_lost_cnt == LOST_W'(LOST_CYCLES - 1))
                                w_state_nxt = S_SEARCH;
                            else
                                w_lost_inc = 1'b1;
                        end
                        default: w_state_nxt = S_FWD;
                    endcase
                end
                S_TURN_L, S_TURN_R: begin
                    // Re-entering the same turn leaves w_cnt_inc low, restarting the dwell.
                    if (r_cnt == CNT_W'(TURN_CYCLES - 1))
                        w_state_nxt = f_steer(w_cls_m, S_FWD);
                    else
                        w_cnt_inc = 1'b1;
                end
                S_SEARCH: begin
                    if (w_any)
                        w_state_nxt = S_FWD;
                    else if (r_cnt == CNT_W'(SEARCH_CYCLES - 1))
                        w_state_nxt = S_STOP;
                    else
                        w_cnt_inc = 1'b1;
                end
                S_STOP: begin
                    if (w_any)
                        w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_cnt_nxt  = w_cnt_inc  ? r_cnt + CNT_W'(1) : '0;
    assign w_lost_nxt = w_lost_inc ? r_lost_cnt + LOST_W'(1) : '0;

    always_comb begin
        w_last_dir_nxt = r_last_dir;
        if (w_state_nxt == S_TURN_L)
            w_last_dir_nxt = 1'b0;
        else if (w_state_nxt == S_TURN_R)
            w_last_dir_nxt = 1'b1;
    end

    assign w_pid_ext = {{2{pid_output[12]}}, pid_output};
    assign w_sum_l   = $signed(15'(FWD_L)) - w_pid_ext;
    assign w_sum_r   = $signed(15'(FWD_R)) + w_pid_ext;

    always_comb begin
        w_servo_l_nxt = '0;
        w_servo_r_nxt = '0;
        case (w_state_nxt)
            S_TURN_L: w_servo_r_nxt = SPD_W'(FWD_R);
            S_TURN_R: w_servo_l_nxt = SPD_W'(FWD_L);
            S_SEARCH: begin
                if (w_last_dir_nxt)
                    w_servo_l_nxt = SPD_W'(FWD_L);
                else
                    w_servo_r_nxt = SPD_W'(FWD_R);
            end
            S_FWD: begin
                if (mode) begin
                    w_servo_l_nxt = f_sat(w_sum_l);
                    w_servo_r_nxt = f_sat(w_sum_r);
                end else begin
                    w_servo_l_nxt = SPD_W'(FWD_L);
                    w_servo_r_nxt = SPD_W'(FWD_R);
                end
            end
            default: begin
                w_servo_l_nxt = '0;
                w_servo_r_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lost_cnt <= '0;
            r_last_dir <= 1'b0;
            r_servo_l  <= '0;
            r_servo_r  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lost_cnt <= w_lost_nxt;
            r_last_dir <= w_last_dir_nxt;
            r_servo_l  <= w_servo_l_nxt;
            r_servo_r  <= w_servo_r_nxt;
        end
    end

    assign servo_l = r_servo_l;
    assign servo_r = r_servo_r;
    assign state_o = r_state;
    assign lost    = (r_state == S_SEARCH) || (r_state == S_STOP);

endmodule

// File: tb/tb_line_steer_fsm.sv
// Bench for line_steer_fsm: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_line_steer_fsm;

    localparam int NS = 5;
    localparam int TC = 6;
    localparam int LC = 4;
    localparam int SC = 12;
    localparam int FL = 155;
    localparam int FR = 137;

    typedef enum int {M_IDLE = 0, M_FWD = 1, M_TL = 2, M_TR = 3,
                      M_SRCH = 4, M_STOP = 5} mst_t;
    typedef enum int {K_NONE, K_LEFT, K_RIGHT, K_CENTER} kls_t;

    typedef struct {
        bit          en;
        bit          md;
        logic [4:0]  s;
        int          pid;
        int          st;
        int          l;
        int          r;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        md  = 1'b0;
    logic [NS-1:0] sens = '0;
    int          pid = 0;
    logic signed [12:0] pid_o;
    logic [7:0]  servo_l;
    logic [7:0]  servo_r;
    logic [2:0]  state_o;
    logic        lost;

    int n_vec = 0;
    int n_err = 0;

    mst_t m_st;
    int   m_age;
    int   m_run;
    bit   m_side;
    int   m_l;
    int   m_r;

    vec_t tbl [12];

    always #5 clk = ~clk;
    always_comb pid_o = 13'(pid);

    line_steer_fsm #(
        .NSENS(NS), .SPD_W(8), .FWD_L(FL), .FWD_R(FR),
        .TURN_CYCLES(TC), .LOST_CYCLES(LC),
        .SEARCH_CYCLES(SC), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(en), .mode(md),
        .sensors(sens), .pid_output(pid_o),
        .servo_l(servo_l), .servo_r(servo_r),
        .state_o(state_o), .lost(lost)
    );

    function automatic kls_t classify(logic [NS-1:0] s, logic m);
        logic [NS-1:0] msk;
        int l;
        int r;
        msk = NS'((1 << (NS / 2)) - 1);
        l = $countones(s >> (NS - NS / 2));
        r = $countones(s & msk);
        if (s == 0) return K_NONE;
        if (m) return K_CENTER;
        if (l > r) return K_LEFT;
        if (r > l) return K_RIGHT;
        return K_CENTER;
    endfunction

    function automatic mst_t steer(kls_t k, mst_t on_none);
        if (k == K_NONE) return on_none;
        if (k == K_LEFT) return M_TL;
        if (k == K_RIGHT) return M_TR;
        return M_FWD;
    endfunction

    function automatic int clamp(int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_age = 0; m_run = 0;
        m_side = 0; m_l = 0; m_r = 0;
    endtask

    task automatic model_step();
        kls_t k;
        mst_t nx;
        bit fresh;
        k = classify(sens, md);
        nx = m_st;
        fresh = 0;
        if (!en) begin
            nx = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE: nx = steer(k, M_STOP);
                M_FWD: begin
                    if (k == K_LEFT) nx = M_TL;
                    else if (k == K_RIGHT) nx = M_TR;
                    else if (k == K_NONE && m_run + 1 >= LC) nx = M_SRCH;
                end
                M_TL, M_TR: begin
                    if (m_age + 1 >= TC) begin
                        nx = steer(k, M_FWD);
                        fresh = 1;
                    end
                end
                M_SRCH: begin
                    if (k != K_NONE) nx = M_FWD;
                    else if (m_age + 1 >= SC) nx = M_STOP;
                end
                default: if (k != K_NONE) nx = M_IDLE;
            endcase
        end
        m_run = (m_st == M_FWD && nx == M_FWD && k == K_NONE) ? m_run + 1 : 0;
        m_age = (fresh || nx != m_st) ? 0 : m_age + 1;
        if (nx == M_TL) m_side = 0;
        if (nx == M_TR) m_side = 1;
        m_st = nx;
        case (nx)
            M_TL:   begin m_l = 0;  m_r = FR; end
            M_TR:   begin m_l = FL; m_r = 0;  end
            M_SRCH: begin
                m_l = m_side ? FL : 0;
                m_r = m_side ? 0 : FR;
            end
            M_FWD: begin
                m_l = md ? clamp(FL - pid) : FL;
                m_r = md ? clamp(FR + pid) : FR;
            end
            default: begin m_l = 0; m_r = 0; end
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(string nm, int st, int l, int r);
        logic el;
        el = (st == 4 || st == 5);
        n_vec++;
        if (state_o !== 3'(st) || servo_l !== 8'(l) ||
            servo_r !== 8'(r) || lost !== el) begin
            n_err++;
            $display("FAIL %s: got st=%0d l=%0d r=%0d lost=%0b, want st=%0d l=%0d r=%0d lost=%0b",
                     nm, state_o, servo_l, servo_r, lost, st, l, r, el);
        end
    endtask

    task automatic step_chk(string nm, int st, int l, int r);
        cyc();
        chk(nm, st, l, r);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        model_reset();
        chk("reset_hold", 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 5'b00100,   0, 1, FL,  FR};
        tbl[1]  = '{1, 1, 5'b00100, 200, 1,  0, 255};
        tbl[2]  = '{1, 1, 5'b00100, -20, 1, 175, 117};
        tbl[3]  = '{1, 1, 5'b11000,   0, 1, FL,  FR};
        tbl[4]  = '{1, 0, 5'b11000,   0, 2,  0,  FR};
        tbl[5]  = '{1, 0, 5'b00100,   0, 2,  0,  FR};
        tbl[6]  = '{1, 0, 5'b00100,   0, 2,  0,  FR};
        tbl[7]  = '{1, 0, 5'b00100,   0, 2,  0,  FR};
        tbl[8]  = '{1, 0, 5'b00100,   0, 2,  0,  FR};
        tbl[9]  = '{1, 0, 5'b00100,   0, 2,  0,  FR};
        tbl[10] = '{1, 0, 5'b00100,   0, 1, FL,  FR};
        tbl[11] = '{1, 0, 5'b00111,   0, 3, FL,   0};

        model_reset();
        rst = 1'b0;
        en = 1'b1;
        sens = 5'($urandom);
        pid = 77;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset", 0, 0, 0);
            sens = 5'($urandom);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            en = tbl[i].en; md = tbl[i].md;
            sens = tbl[i].s; pid = tbl[i].pid;
            step_chk($sformatf("tbl%0d", i), tbl[i].st, tbl[i].l, tbl[i].r);
        end

        sens = 5'b00100; pid = 0; md = 0;
        for (int i = 1; i < TC; i++) step_chk("tr_dwell", 3, FL, 0);
        step_chk("tr_exit", 1, FL, FR);
        sens = '0;
        for (int i = 1; i < LC; i++) step_chk("coast", 1, FL, FR);
        step_chk("search_in", 4, FL, 0);
        step_chk("search_hold", 4, FL, 0);
        sens = 5'b00001;
        step_chk("regain", 1, FL, FR);

        sens = '0;
        for (int i = 1; i < LC; i++) step_chk("coast2", 1, FL, FR);
        step_chk("search2", 4, FL, 0);
        for (int i = 1; i < SC; i++) step_chk("search_run", 4, FL, 0);
        step_chk("timeout", 5, 0, 0);
        step_chk("stop_hold", 5, 0, 0);
        sens = 5'b00100;
        step_chk("stop_idle", 0, 0, 0);
        step_chk("idle_fwd", 1, FL, FR);

        sens = 5'b11000;
        step_chk("to_tl", 2, 0, FR);
        en = 1'b0;
        step_chk("en_off", 0, 0, 0);
        step_chk("en_off2", 0, 0, 0);
        en = 1'b1; sens = 5'b00100;
        step_chk("en_on", 1, FL, FR);

        sens = '0;
        for (int i = 1; i < LC; i++) step_chk("coast3", 1, FL, FR);
        step_chk("search3", 4, 0, FR);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        sens = 5'b00100;
        step_chk("post_rst", 1, FL, FR);

        pulse_reset();
        begin
            int run;
            run = 0;
            for (int i = 0; i < 4000; i++) begin
                if (run == 0) begin
                    run = int'($urandom_range(1, 8));
                    if ($urandom_range(0, 9) < 4) sens = '0;
                    else sens = 5'($urandom);
                end
                run--;
                en = ($urandom_range(0, 31) != 0);
                if ($urandom_range(0, 63) == 0) md = ~md;
                if ($urandom_range(0, 1) == 1)
                    pid = int'($urandom_range(0, 8191)) - 4096;
                else
                    pid = int'($urandom_range(0, 80)) - 40;
                cyc();
                chk("rand", int'(m_st), m_l, m_r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_steer_fsm.md
# line_steer_fsm

Parametrised steering controller for the line follower. It converts an N-sensor reflectance vector and, optionally, the PID correction into left/right servo drive bytes. Compared with the two-sensor servo handler it adds a configurable sensor count and speeds, a PID drive mode, minimum turn dwell, lost-line coasting, and a timed search toward the last seen line side. It sits between the sensor synchroniser / PID block and the servo PWM generators.

## Interface
- NSENS, 5: number of line sensors; must be ≥2. Bit NSENS-1 is the leftmost sensor.
- SPD_W, 8: servo command width.
- FWD_L, 155: left servo forward command.
- FWD_R, 137: right servo forward command.
- TURN_CYCLES, 500: turn dwell in cycles; must be ≥1.
- LOST_CYCLES, 1000: consecutive all-off cycles in FWD before search starts; must be ≥1.
- SEARCH_CYCLES, 200000: maximum search duration; must be ≥1.
- CNT_W, 21: width of the dwell/search counter; must hold max(TURN_CYCLES, SEARCH_CYCLES).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low (asserted when 0).
- enable, in, 1: run request.
- mode, in, 1: 0 = bang-bang, 1 = PID drive.
- sensors, in, NSENS: line sensor vector, synchronous to clk.
- pid_output, in, 13: signed two's-complement correction.
- servo_l, out, SPD_W: left servo command, registered.
- servo_r, out, SPD_W: right servo command, registered.
- state_o, out, 3: current state encoding.
- lost, out, 1: high while in SEARCH or STOP.

## Operation
- States and encodings: IDLE=0, FWD=1, TURN_L=2, TURN_R=3, SEARCH=4, STOP=5. Encodings 6 and 7 go to IDLE.
- Sensor classification (combinational):
  - L = popcount of the upper floor(NSENS/2) bits.
  - R = popcount of the lower floor(NSENS/2) bits. The middle bit for odd NSENS counts only toward "any".
  - Class NONE: all bits 0.
  - Class LEFT: L>R.
  - Class RIGHT: R>L.
  - Class CENTER: otherwise.
- In mode=1, LEFT and RIGHT are treated as CENTER.
- enable=0 forces the next state to IDLE from any state. This has priority over all other transitions.
- IDLE, with enable=1:
  - NONE goes to STOP.
  - CENTER goes to FWD.
  - LEFT goes to TURN_L.
  - RIGHT goes to TURN_R.
- FWD:
  - LEFT goes to TURN_L; RIGHT goes to TURN_R.
  - NONE increments lost_cnt. The block coasts in FWD until lost_cnt==LOST_CYCLES-1 while NONE, then goes to SEARCH.
  - Any non-NONE class clears lost_cnt.
- TURN_L / TURN_R:
  - cnt increments every cycle.
  - At cnt==TURN_CYCLES-1, the next state follows the IDLE classification rule, except that NONE goes to FWD. Re-entering the same turn restarts cnt.
  - Dwell is exactly TURN_CYCLES cycles.
- SEARCH:
  - Any sensor set goes to FWD.
  - Otherwise, at cnt==SEARCH_CYCLES-1, goes to STOP.
- STOP: any sensor set goes to IDLE.
- cnt and lost_cnt are cleared on every state change.
- last_dir is set to 0 on entry to TURN_L and to 1 on entry to TURN_R. It resets to 0.
- Outputs, computed from the next state and registered:
  - IDLE and STOP: servo_l=0, servo_r=0.
  - TURN_L, and SEARCH with last_dir=0: servo_l=0, servo_r=FWD_R.
  - TURN_R, and SEARCH with last_dir=1: servo_l=FWD_L, servo_r=0.
  - FWD with mode=0: servo_l=FWD_L, servo_r=FWD_R.
  - FWD with mode=1: servo_l=sat(FWD_L−pid), servo_r=sat(FWD_R+pid).
- PID arithmetic: 15-bit signed intermediate, saturated to [0, 2^SPD_W−1].
- mode is sampled every cycle. A change while in FWD takes effect on the next edge.

## Timing
- Reset (rst=0), asynchronous:
  - servo_l=0, servo_r=0, state_o=0, lost=0.
  - cnt=0, lost_cnt=0, last_dir=0.
- Release is synchronous to the next clk edge.
- Latency is one cycle: sensors/enable/pid sampled at edge k are reflected in state_o and the servo outputs after edge k. No combinational input-to-output path exists.
- Reset asserted mid-turn or mid-search forces the outputs to 0 immediately, without waiting for a clock. After release the block restarts from IDLE.
- The search covers SEARCH_CYCLES cycles of search drive before STOP, unless the line is regained earlier.

## Test plan
- Reset and enable: hold rst=0 with random inputs → all outputs 0. Release with enable=1 and sensors=5'b00100 → state_o=1, servo=(155,137) one cycle later.
- Left turn dwell: in FWD apply sensors=5'b11000 for 1 cycle, then 5'b00100 → state_o=2, servo=(0,137) for exactly 500 cycles, then state_o=1.
- PID saturation: mode=1, FWD, pid=+200 → servo_l=0, servo_r=255. pid=−20 → servo=(175,117).
- Lost and regain: TURN_R then FWD, sensors=0 → stays in FWD for LOST_CYCLES cycles, then SEARCH with servo=(155,0) and lost=1. Set sensors=5'b00001 mid-search → FWD on the next edge, lost=0.
- Search timeout: sensors=0 held through SEARCH → STOP after SEARCH_CYCLES cycles, servo=(0,0). sensors=5'b00100 → IDLE, then FWD.
- Priority and async reset: enable=0 during TURN_L → IDLE and outputs 0 on the next edge. Pulse rst=0 between clock edges during SEARCH → outputs 0 immediately.
